// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter
//   Shares one synchronous-read font ROM (128 glyphs x 16 rows x 8 bits) between the VGA text
//   pixel pipeline (requester 0) and the overlay/cursor renderer (requester 1). At most one
//   glyph-row lookup is granted per cycle; the granted {char,row} drives the ROM address and the
//   returned row is steered back to its owner exactly ROM_LAT cycles later.
//
// Parameters
//   FIXED_PRIO  0 = round-robin on ties, 1 = requester 0 always wins
//   ROM_LAT     ROM read latency in cycles (1..4)
//   STALL_W     width of the saturating stall counter
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/char/row/ready     lookup request handshake (ready is combinational)
//   rspN_valid/data               one-cycle response, data forced to 0 when not valid
//   rom_addr, rom_data            font ROM address out / row data in
//   stall_cnt                     cycles with at least one valid request left waiting

module font_rom_arbiter #(
   parameter int unsigned FIXED_PRIO = 0,
   parameter int unsigned ROM_LAT    = 1,
   parameter int unsigned STALL_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req0_valid,
   input  logic [6:0]         req0_char,
   input  logic [3:0]         req0_row,
   output logic               req0_ready,
   output logic               rsp0_valid,
   output logic [7:0]         rsp0_data,
   input  logic               req1_valid,
   input  logic [6:0]         req1_char,
   input  logic [3:0]         req1_row,
   output logic               req1_ready,
   output logic               rsp1_valid,
   output logic [7:0]         rsp1_data,
   output logic [10:0]        rom_addr,
   input  logic [7:0]         rom_data,
   output logic [STALL_W-1:0] stall_cnt
);

   // 1 = requester 1 was granted most recently; reset to 1 so requester 0 wins the first tie.
   logic last_q, last_d;
   logic gnt0, gnt1;
   logic stall_evt;
   logic [STALL_W-1:0] stall_q, stall_d;

   // Response pipeline: valid and owner id of each lookup still inside the ROM.
   logic [ROM_LAT-1:0] pv_q;
   logic [ROM_LAT-1:0] pid_q;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (req0_valid && req1_valid) begin
         if (FIXED_PRIO != 0 || last_q) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end else begin
         gnt0 = req0_valid;
         gnt1 = req1_valid;
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt0) begin
         last_d = 1'b0;
      end else if (gnt1) begin
         last_d = 1'b1;
      end
   end

   always_comb begin
      rom_addr = 11'h000;
      if (gnt0) begin
         rom_addr = {req0_char, req0_row};
      end else if (gnt1) begin
         rom_addr = {req1_char, req1_row};
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign stall_evt = (req0_valid && !gnt0) || (req1_valid && !gnt1);

   always_comb begin
      stall_d = stall_q;
      if (stall_evt && (stall_q != {STALL_W{1'b1}})) begin
         stall_d = stall_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= 1'b1;
         stall_q <= '0;
         pv_q    <= '0;
         pid_q   <= '0;
      end else begin
         last_q   <= last_d;
         stall_q  <= stall_d;
         pv_q[0]  <= gnt0 | gnt1;
         pid_q[0] <= gnt1;
         for (int i = 1; i < ROM_LAT; i++) begin
            pv_q[i]  <= pv_q[i-1];
            pid_q[i] <= pid_q[i-1];
         end
      end
   end

   // The last stage lines up with the ROM data for the address sampled ROM_LAT edges earlier.
   assign rsp0_valid = pv_q[ROM_LAT-1] && !pid_q[ROM_LAT-1];
   assign rsp1_valid = pv_q[ROM_LAT-1] &&  pid_q[ROM_LAT-1];
   assign rsp0_data  = rsp0_valid ? rom_data : 8'h00;
   assign rsp1_data  = rsp1_valid ? rom_data : 8'h00;
   assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Testbench for font_rom_arbiter: two instances (round-robin/ROM_LAT=1/STALL_W=16 and
// fixed-priority/ROM_LAT=3/STALL_W=4), each with its own ROM model and reference model.

module tb_font_rom_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic rand_en;

   // Directed stimulus shared by both instances.
   logic       d0v, d1v;
   logic [6:0] d0c, d1c;
   logic [3:0] d0r, d1r;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   typedef struct {
      int unsigned due;
      int          id;
      logic [7:0]  data;
   } exp_t;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Font contents: a few known glyph rows, arbitrary filler elsewhere.
   function automatic logic [7:0] glyph(input logic [10:0] a);
      case (a)
         11'h413: glyph = 8'h18;
         11'h303: glyph = 8'h3C;
         11'h31A: glyph = 8'h7E;
         default: glyph = a[7:0] ^ {a[10:8], a[4:0]} ^ 8'h5A;
      endcase
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_inst
      localparam int unsigned Fp       = (k == 0) ? 0 : 1;
      localparam int unsigned Lat      = (k == 0) ? 1 : 3;
      localparam int unsigned Sw       = (k == 0) ? 16 : 4;
      localparam int unsigned StallMax = (1 << Sw) - 1;

      logic          v0, v1, rdy0, rdy1, rv0, rv1;
      logic [6:0]    c0, c1;
      logic [3:0]    r0, r1;
      logic [7:0]    rd0, rd1, rom_data;
      logic [10:0]   addr;
      logic [Sw-1:0] stall;

      // Random requesters (hold until accepted).
      logic       xv0, xv1;
      logic [6:0] xc0, xc1;
      logic [3:0] xr0, xr1;
      logic       acc0, acc1;

      assign v0 = rand_en ? xv0 : d0v;
      assign c0 = rand_en ? xc0 : d0c;
      assign r0 = rand_en ? xr0 : d0r;
      assign v1 = rand_en ? xv1 : d1v;
      assign c1 = rand_en ? xc1 : d1c;
      assign r1 = rand_en ? xr1 : d1r;

      font_rom_arbiter #(
         .FIXED_PRIO(Fp),
         .ROM_LAT   (Lat),
         .STALL_W   (Sw)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .req0_valid(v0),
         .req0_char (c0),
         .req0_row  (r0),
         .req0_ready(rdy0),
         .rsp0_valid(rv0),
         .rsp0_data (rd0),
         .req1_valid(v1),
         .req1_char (c1),
         .req1_row  (r1),
         .req1_ready(rdy1),
         .rsp1_valid(rv1),
         .rsp1_data (rd1),
         .rom_addr  (addr),
         .rom_data  (rom_data),
         .stall_cnt (stall)
      );

      // Synchronous-read ROM with Lat cycles of latency.
      logic [7:0] rom_pipe [Lat];
      initial for (int i = 0; i < Lat; i++) rom_pipe[i] = 8'h00;
      always @(posedge clk) begin
         rom_pipe[0] <= glyph(addr);
         for (int i = 1; i < Lat; i++) rom_pipe[i] <= rom_pipe[i-1];
      end
      assign rom_data = rom_pipe[Lat-1];

      // Reference model: expected responses are a queue of (due cycle, owner, data).
      int          last;
      int          stall_m;
      int unsigned cyc;
      exp_t        q[$];

      initial begin
         last    = 1;
         stall_m = 0;
         cyc     = 0;
         acc0    = 1'b0;
         acc1    = 1'b0;
      end

      always @(negedge clk) begin : p_model
         int         g;
         logic       ev0, ev1;
         logic [7:0] ed0, ed1;
         logic [10:0] ea;
         exp_t       e;
         cyc++;
         if (!rst_n) begin
            q.delete();
            last    = 1;
            stall_m = 0;
         end
         g = -1;
         if (v0 && v1)  g = (Fp != 0) ? 0 : ((last == 1) ? 0 : 1);
         else if (v0)   g = 0;
         else if (v1)   g = 1;
         ea = (g == 0) ? {c0, r0} : (g == 1) ? {c1, r1} : 11'h000;
         ev0 = 1'b0; ev1 = 1'b0; ed0 = 8'h00; ed1 = 8'h00;
         if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.id == 0) begin ev0 = 1'b1; ed0 = e.data; end
            else           begin ev1 = 1'b1; ed1 = e.data; end
         end
         check_eq($sformatf("i%0d req0_ready", k), 32'(rdy0), 32'(g == 0));
         check_eq($sformatf("i%0d req1_ready", k), 32'(rdy1), 32'(g == 1));
         check_eq($sformatf("i%0d rom_addr", k), 32'(addr), 32'(ea));
         check_eq($sformatf("i%0d rsp0_valid", k), 32'(rv0), 32'(ev0));
         check_eq($sformatf("i%0d rsp1_valid", k), 32'(rv1), 32'(ev1));
         check_eq($sformatf("i%0d rsp0_data", k), 32'(rd0), 32'(ed0));
         check_eq($sformatf("i%0d rsp1_data", k), 32'(rd1), 32'(ed1));
         check_eq($sformatf("i%0d stall_cnt", k), 32'(stall), 32'(stall_m));
         if (rst_n) begin
            if (g >= 0) begin
               last = g;
               q.push_back('{due: cyc + Lat, id: g, data: glyph(ea)});
            end
            if ((v0 && g != 0) || (v1 && g != 1)) begin
               if (stall_m < int'(StallMax)) stall_m++;
            end
         end
         acc0 = rst_n && (g == 0);
         acc1 = rst_n && (g == 1);
      end

      initial begin
         xv0 = 1'b0; xv1 = 1'b0;
         xc0 = '0;   xc1 = '0;
         xr0 = '0;   xr1 = '0;
         forever begin
            @(posedge clk);
            #1;
            if (!rand_en) begin
               xv0 = 1'b0;
               xv1 = 1'b0;
            end else begin
               if (!xv0 || acc0) begin
                  xv0 = ($urandom_range(0, 3) != 0);
                  xc0 = 7'($urandom);
                  xr0 = 4'($urandom);
               end
               if (!xv1 || acc1) begin
                  xv1 = ($urandom_range(0, 2) != 0);
                  xc1 = 7'($urandom);
                  xr1 = 4'($urandom);
               end
            end
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      rand_en = 1'b0;
      d0v = 1'b0; d0c = '0; d0r = '0;
      d1v = 1'b0; d1c = '0; d1r = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset.
      @(negedge clk);
      check_eq("reset rsp0_valid", 32'(g_inst[0].rv0), 32'd0);
      check_eq("reset rsp1_valid", 32'(g_inst[1].rv1), 32'd0);
      repeat (10) @(negedge clk);
      check_eq("idle stall i0", 32'(g_inst[0].stall), 32'd0);
      check_eq("idle stall i1", 32'(g_inst[1].stall), 32'd0);

      // Single lookup: 'A' row 3.
      @(posedge clk);
      #1 d0v = 1'b1; d0c = 7'd65; d0r = 4'd3;
      @(negedge clk);
      check_eq("A rom_addr", 32'(g_inst[0].addr), 32'h413);
      check_eq("A req0_ready", 32'(g_inst[0].rdy0), 32'd1);
      @(posedge clk);
      #1 d0v = 1'b0;
      @(negedge clk);
      check_eq("A i0 rsp0_valid", 32'(g_inst[0].rv0), 32'd1);
      check_eq("A i0 rsp0_data", 32'(g_inst[0].rd0), 32'h18);
      check_eq("A i0 rsp1_valid", 32'(g_inst[0].rv1), 32'd0);
      repeat (2) @(negedge clk);
      check_eq("A i1 rsp0_valid", 32'(g_inst[1].rv0), 32'd1);
      check_eq("A i1 rsp0_data", 32'(g_inst[1].rd0), 32'h18);

      // Reset one cycle after a grant: lookup discarded, pointer back to 1.
      @(posedge clk);
      #1 d0v = 1'b1; d0c = 7'd66; d0r = 4'd5;
      @(posedge clk);
      #1 d0v = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      check_eq("mid reset rsp0_valid i0", 32'(g_inst[0].rv0), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      d0v = 1'b1; d0c = 7'd48; d0r = 4'd3;
      d1v = 1'b1; d1c = 7'd49; d1r = 4'd10;

      // Tie for 6 cycles.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_eq($sformatf("rr grant0 c%0d", i), 32'(g_inst[0].rdy0), 32'(i % 2 == 0));
         check_eq($sformatf("rr grant1 c%0d", i), 32'(g_inst[0].rdy1), 32'(i % 2 == 1));
         check_eq($sformatf("fp grant0 c%0d", i), 32'(g_inst[1].rdy0), 32'd1);
         if (i > 0) begin
            if (i % 2 == 1) check_eq("rr rsp 0x3C", 32'(g_inst[0].rd0), 32'h3C);
            else            check_eq("rr rsp 0x7E", 32'(g_inst[0].rd1), 32'h7E);
         end
      end
      @(posedge clk);
      #1 d0v = 1'b0; d1v = 1'b0;
      @(negedge clk);
      check_eq("rr stall i0", 32'(g_inst[0].stall), 32'd6);
      check_eq("rr stall i1", 32'(g_inst[1].stall), 32'd6);

      // Fixed priority: both valid 4 cycles, then req0 drops.
      @(posedge clk);
      #1 d0v = 1'b1; d1v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq($sformatf("fp req1_ready c%0d", i), 32'(g_inst[1].rdy1), 32'd0);
      end
      @(posedge clk);
      #1 d0v = 1'b0;
      @(negedge clk);
      check_eq("fp req1 served", 32'(g_inst[1].rdy1), 32'd1);
      check_eq("fp stall", 32'(g_inst[1].stall), 32'd10);
      @(posedge clk);
      #1 d1v = 1'b0;

      // Saturation of the 4-bit counter.
      @(posedge clk);
      #1 d0v = 1'b1; d1v = 1'b1;
      repeat (20) @(negedge clk);
      @(posedge clk);
      #1 d0v = 1'b0; d1v = 1'b0;
      @(negedge clk);
      check_eq("sat stall", 32'(g_inst[1].stall), 32'd15);
      repeat (3) @(negedge clk);
      check_eq("sat hold", 32'(g_inst[1].stall), 32'd15);

      // Random traffic with occasional reset pulses.
      @(posedge clk);
      #1 rand_en = 1'b1;
      repeat (3000) begin
         @(posedge clk);
         #1 rst_n = ($urandom_range(0, 99) != 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1; rand_en = 1'b0;
      repeat (10) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
